prop_plug_tx: RTL and testbench



---
 rtl/prop_plug_tx.sv | 163 ++++++++++++++++
 tb/tb_prop_plug_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prop_plug_tx.sv
// prop_plug_tx: host-side Prop Plug emulator.
// Pulses the target's active-low reset and waits out the boot window. It then
// sends bytes from a valid/ready stream as 8N1 frames on the P31 serial line.
// Optional feature macro: PROPPLUG_RESET_EN enables the target reset/boot-wait
// sequencing. Without it the block is a plain 8N1 transmitter.
module prop_plug_tx #(
  parameter int unsigned BAUD_DIV         = 1389,
  parameter int unsigned RES_CYCLES       = 1600000,
  parameter int unsigned BOOT_WAIT_CYCLES = 16000000
) (
  input  logic       clock,
  input  logic       resn,
  input  logic       reset_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       target_resn,
  output logic       busy
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

`ifdef PROPPLUG_RESET_EN
  localparam int unsigned DLY_MAX = (RES_CYCLES > BOOT_WAIT_CYCLES) ? RES_CYCLES : BOOT_WAIT_CYCLES;
  localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam logic [DLY_W-1:0] RES_LAST  = DLY_W'(RES_CYCLES - 1);
  localparam logic [DLY_W-1:0] BOOT_LAST = DLY_W'(BOOT_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_BOOT_WAIT, S_START, S_DATA, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic              tx_q, tx_d;

`ifdef PROPPLUG_RESET_EN
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              target_resn_q, target_resn_d;
`else
  logic              unused_reset_req;
  assign unused_reset_req = reset_req;
`endif

  // Handshake and status are decoded straight from the current state
`ifdef PROPPLUG_RESET_EN
  assign tx_ready    = (state_q == S_IDLE) && !reset_req;
  assign target_resn = target_resn_q;
`else
  assign tx_ready    = (state_q == S_IDLE);
  assign target_resn = 1'b1;
`endif
  assign busy = (state_q != S_IDLE);
  assign tx   = tx_q;

  // Next-state, counter and output computation
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;
`ifdef PROPPLUG_RESET_EN
    dly_d         = dly_q;
    target_resn_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = S_START;
          baud_d  = BAUD_LAST;
          shift_d = tx_data;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_LAST;
          idx_d   = '0;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) state_d = S_IDLE;
        else              baud_d  = baud_q - 1'b1;
      end
`ifdef PROPPLUG_RESET_EN
      S_RESET: begin
        if (dly_q == '0) begin
          state_d = S_BOOT_WAIT;
          dly_d   = BOOT_LAST;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_BOOT_WAIT: begin
        if (dly_q == '0) state_d = S_IDLE;
        else             dly_d   = dly_q - 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef PROPPLUG_RESET_EN
    // A request from any state (re)starts the full reset pulse. The outputs
    // are taken from the next state here, so an aborted frame releases the
    // line and the target reset asserts on the very edge that sees the request.
    if (reset_req) begin
      state_d = S_RESET;
      dly_d   = RES_LAST;
      tx_d    = 1'b1;
    end
    target_resn_d = (state_d != S_RESET);
`endif
  end

  // State, counters and registered line outputs
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
`ifdef PROPPLUG_RESET_EN
      dly_q         <= '0;
      target_resn_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef PROPPLUG_RESET_EN
      dly_q         <= dly_d;
      target_resn_q <= target_resn_d;
`endif
    end
  end

endmodule

// File: tb/tb_prop_plug_tx.sv
// Testbench for prop_plug_tx with BAUD_DIV=4, RES_CYCLES=10, BOOT_WAIT_CYCLES=20.
// Line waveforms are predicted from the 8N1 framing rules. Reset-pulse timing
// is predicted from the cycle counts. Reset tests need PROPPLUG_RESET_EN.
module tb_prop_plug_tx;
  localparam int BAUD  = 4;
  localparam int RES   = 10;
  localparam int BOOT  = 20;
  localparam int FRAME = 10 * BAUD;

  logic       clock = 1'b0;
  logic       resn = 1'b0;
  logic       reset_req = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, tx, target_resn, busy;

  int tests_run = 0;
  int fails = 0;

  always #5 clock = ~clock;

  prop_plug_tx #(
    .BAUD_DIV(BAUD),
    .RES_CYCLES(RES),
    .BOOT_WAIT_CYCLES(BOOT)
  ) dut (
    .clock(clock),
    .resn(resn),
    .reset_req(reset_req),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .target_resn(target_resn),
    .busy(busy)
  );

  // Expected line: index 0 is the idle cycle right after the accepting edge.
  // Indices 1..FRAME hold start, 8 data bits LSB first, and stop.
  function automatic logic [FRAME:0] frame_wave(input logic [7:0] b);
    logic [FRAME:0] w;
    w[0] = 1'b1;
    for (int t = 0; t < FRAME; t++) begin
      int slot;
      slot = t / BAUD;
      if (slot == 0)      w[t+1] = 1'b0;
      else if (slot == 9) w[t+1] = 1'b1;
      else                w[t+1] = b[slot-1];
    end
    return w;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_wait_ready: tx_ready=%b required 1 within 200 cycles", tag, tx_ready);
    end
  endtask

  task automatic send_capture(input logic [7:0] b, output logic [FRAME:0] txw,
                              output logic [FRAME:0] rdyw, output logic [FRAME:0] trw);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clock);
    #1 tx_valid = 1'b0;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clock);
      txw[i]  = tx;
      rdyw[i] = tx_ready;
      trw[i]  = target_resn;
    end
  endtask

  task automatic test_reset;
    resn = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    tests_run++; if (tx !== 1'b1)          begin fails++; $display("FAIL rst_tx: got %b required 1", tx); end
    tests_run++; if (target_resn !== 1'b1) begin fails++; $display("FAIL rst_target_resn: got %b required 1", target_resn); end
    tests_run++; if (busy !== 1'b0)        begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests_run++; if (tx_ready !== 1'b1)    begin fails++; $display("FAIL rst_tx_ready: got %b required 1", tx_ready); end
    @(negedge clock);
    resn = 1'b1;
    @(negedge clock);
    tests_run++; if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++; $display("FAIL rst_release: busy=%b tx=%b required busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input string tag);
    logic [FRAME:0] txw, rdyw, trw, exp_tx, exp_rdy;
    wait_ready(tag);
    send_capture(b, txw, rdyw, trw);
    exp_tx  = frame_wave(b);
    exp_rdy = '0;
    exp_rdy[FRAME] = 1'b1;
    tests_run++;
    if (txw !== exp_tx) begin
      fails++; $display("FAIL %s_line byte=%h: got %h required %h", tag, b, txw, exp_tx);
    end
    tests_run++;
    if (rdyw !== exp_rdy) begin
      fails++; $display("FAIL %s_ready byte=%h: got %h required %h", tag, b, rdyw, exp_rdy);
    end
    tests_run++;
    if (trw !== '1) begin
      fails++; $display("FAIL %s_target_resn byte=%h: got %h required all ones", tag, b, trw);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      test_frame(b, "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [2*FRAME+2:0] w, exp;
    logic [FRAME:0] f0, f1;
    wait_ready("b2b");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clock);
    #1 tx_data = 8'hFF;
    for (int i = 0; i <= 2*FRAME+2; i++) begin
      @(negedge clock);
      w[i] = tx;
      if (i == FRAME + 1) tx_valid = 1'b0;
    end
    f0  = frame_wave(8'h00);
    f1  = frame_wave(8'hFF);
    exp = '1;
    for (int t = 1; t <= FRAME; t++) begin
      exp[t]           = f0[t];
      exp[FRAME+1+t]   = f1[t];
    end
    tests_run++;
    if (w !== exp) begin
      fails++; $display("FAIL b2b_line: got %h required %h", w, exp);
    end
  endtask

`ifdef PROPPLUG_RESET_EN
  task automatic test_reset_pulse;
    int low_cnt, first_low, last_low, last_busy, tx_zero;
    logic rdy_at_end;
    wait_ready("rpulse");
    reset_req = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 8'h5A;
    #1;
    tests_run++;
    if (tx_ready !== 1'b0) begin
      fails++; $display("FAIL rpulse_ready_gated: got %b required 0", tx_ready);
    end
    @(posedge clock);
    #1 begin reset_req = 1'b0; tx_valid = 1'b0; end
    low_cnt = 0; first_low = -1; last_low = -1; last_busy = -1; tx_zero = 0;
    rdy_at_end = 1'b0;
    for (int i = 0; i < RES + BOOT + 5; i++) begin
      @(negedge clock);
      if (target_resn === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      if (busy === 1'b1) last_busy = i;
      if (tx !== 1'b1) tx_zero++;
      if (i == RES + BOOT) rdy_at_end = tx_ready;
    end
    tests_run++; if (low_cnt != RES || first_low != 0 || last_low != RES - 1) begin
      fails++; $display("FAIL rpulse_target_low: got count=%0d first=%0d last=%0d required %0d/0/%0d", low_cnt, first_low, last_low, RES, RES - 1);
    end
    tests_run++; if (last_busy != RES + BOOT - 1) begin
      fails++; $display("FAIL rpulse_busy: got last busy index %0d required %0d", last_busy, RES + BOOT - 1);
    end
    tests_run++; if (rdy_at_end !== 1'b1) begin
      fails++; $display("FAIL rpulse_ready_after: got %b required 1", rdy_at_end);
    end
    tests_run++; if (tx_zero != 0) begin
      fails++; $display("FAIL rpulse_no_byte: got %0d non-idle line cycles required 0", tx_zero);
    end
  endtask

  task automatic test_restart;
    int low_cnt, last_low, last_busy;
    wait_ready("restart");
    reset_req = 1'b1;
    @(posedge clock);
    #1 reset_req = 1'b0;
    low_cnt = 0; last_low = -1; last_busy = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (i == 15) reset_req = 1'b1;
      if (i == 16) reset_req = 1'b0;
      if (target_resn === 1'b0) begin low_cnt++; last_low = i; end
      if (busy === 1'b1) last_busy = i;
    end
    tests_run++; if (low_cnt != 2 * RES || last_low != 16 + RES - 1) begin
      fails++; $display("FAIL restart_target_low: got count=%0d last=%0d required %0d/%0d", low_cnt, last_low, 2 * RES, 16 + RES - 1);
    end
    tests_run++; if (last_busy != 16 + RES + BOOT - 1) begin
      fails++; $display("FAIL restart_busy: got last busy index %0d required %0d", last_busy, 16 + RES + BOOT - 1);
    end
  endtask

  task automatic test_abort;
    int low_cnt, tx_zero;
    wait_ready("abort");
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clock);
    #1 tx_valid = 1'b0;
    repeat (18) @(negedge clock);
    reset_req = 1'b1;
    @(posedge clock);
    #1 reset_req = 1'b0;
    tests_run++; if (tx !== 1'b1 || target_resn !== 1'b0) begin
      fails++; $display("FAIL abort_next_edge: tx=%b target_resn=%b required tx=1 target_resn=0", tx, target_resn);
    end
    low_cnt = 0; tx_zero = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (target_resn === 1'b0) low_cnt++;
      if (tx !== 1'b1) tx_zero++;
    end
    tests_run++; if (tx_zero != 0) begin
      fails++; $display("FAIL abort_frame_dropped: got %0d non-idle line cycles required 0", tx_zero);
    end
    tests_run++; if (low_cnt != RES) begin
      fails++; $display("FAIL abort_target_low: got %0d cycles required %0d", low_cnt, RES);
    end
    tests_run++; if (tx_ready !== 1'b1) begin
      fails++; $display("FAIL abort_ready_after: got %b required 1", tx_ready);
    end
  endtask
`else
  task automatic test_ignore_reset;
    logic [FRAME:0] txw, trw, exp_tx;
    wait_ready("noreset");
    tx_data   = 8'h55;
    tx_valid  = 1'b1;
    reset_req = 1'b1;
    #1;
    tests_run++; if (tx_ready !== 1'b1) begin
      fails++; $display("FAIL noreset_ready: got %b required 1", tx_ready);
    end
    @(posedge clock);
    #1 begin tx_valid = 1'b0; reset_req = 1'b0; end
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clock);
      txw[i] = tx;
      trw[i] = target_resn;
    end
    exp_tx = frame_wave(8'h55);
    tests_run++; if (txw !== exp_tx) begin
      fails++; $display("FAIL noreset_line: got %h required %h", txw, exp_tx);
    end
    tests_run++; if (trw !== '1) begin
      fails++; $display("FAIL noreset_target_resn: got %h required all ones", trw);
    end
  endtask
`endif

  task automatic test_async;
    wait_ready("async");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clock);
    #1 tx_valid = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++; if (tx !== 1'b0) begin
      fails++; $display("FAIL async_pre_line: got %b required 0", tx);
    end
    #2 resn = 1'b0;
    #1;
    tests_run++; if (tx !== 1'b1 || target_resn !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL async_frame: tx=%b target_resn=%b busy=%b required 1/1/0", tx, target_resn, busy);
    end
    @(negedge clock);
    resn = 1'b1;
    @(negedge clock);
    tests_run++; if (busy !== 1'b0 || tx_ready !== 1'b1 || tx !== 1'b1) begin
      fails++; $display("FAIL async_release: busy=%b tx_ready=%b tx=%b required 0/1/1", busy, tx_ready, tx);
    end
`ifdef PROPPLUG_RESET_EN
    reset_req = 1'b1;
    @(posedge clock);
    #1 reset_req = 1'b0;
    repeat (4) @(negedge clock);
    tests_run++; if (target_resn !== 1'b0) begin
      fails++; $display("FAIL async_pre_pulse: target_resn=%b required 0", target_resn);
    end
    #2 resn = 1'b0;
    #1;
    tests_run++; if (target_resn !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL async_pulse: target_resn=%b busy=%b required 1/0", target_resn, busy);
    end
    @(negedge clock);
    resn = 1'b1;
    @(negedge clock);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_frame(8'hA5, "a5");
    test_random;
    test_back_to_back;
`ifdef PROPPLUG_RESET_EN
    test_reset_pulse;
    test_restart;
    test_abort;
`else
    test_ignore_reset;
`endif
    test_async;
    test_frame(8'h81, "post_async");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
